// File: rtl/divide.sv
// Iterative radix-2 restoring divider: {dividend, divisor} in, {quotient, remainder} out after N+1 cycles.
// Define DIVIDE_SIGNED_EN for two's-complement operands; the default build is unsigned.
module divide #(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_nd,
  input  logic [MWIDTH-1:0] in_m,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_nd,
  output logic [MWIDTH-1:0] out_m,
  output logic              busy,
  output logic              error
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      dvd_sh;
  logic [N-1:0]      dvs_mag;
  logic [N-1:0]      quo;
  logic [N-1:0]      rem;
  logic              div_zero;
  logic [MWIDTH-1:0] tag;

  logic [N-1:0]      a_in, b_in, a_mag, b_mag;
  logic [N:0]        r_sh;
  logic [N-1:0]      r_diff;
  logic              r_ge;
  logic [N-1:0]      q_fix, r_fix;

  assign a_in = in_data[WIDTH-1:N];
  assign b_in = in_data[N-1:0];

`ifdef DIVIDE_SIGNED_EN
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic signed [N-1:0] a_s, b_s;
  logic                q_neg, r_neg, ovf, ovf_in;

  function automatic logic [N-1:0] negate(input logic [N-1:0] v);
    return (~v) + N'(1);
  endfunction

  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v);
    return v[N-1] ? negate(v) : v;
  endfunction

  assign a_s    = a_in;
  assign b_s    = b_in;
  assign a_mag  = magnitude(a_s);
  assign b_mag  = magnitude(b_s);
  assign ovf_in = (a_in == MIN_NEG) && (b_in == {N{1'b1}});

  // Sign restoration and saturation of the unsigned core result
  always_comb begin
    q_fix = q_neg ? negate(quo) : quo;
    r_fix = r_neg ? negate(rem) : rem;
    if (ovf) begin
      q_fix = MAX_POS;
      r_fix = '0;
    end else if (div_zero) begin
      q_fix = r_neg ? MIN_NEG : MAX_POS;
    end
  end
`else
  assign a_mag = a_in;
  assign b_mag = b_in;
  assign q_fix = quo;
  assign r_fix = rem;
`endif

  // Restoring step: the partial remainder never exceeds N bits after the subtract
  assign r_sh   = {rem, dvd_sh[N-1]};
  assign r_ge   = r_sh >= {1'b0, dvs_mag};
  assign r_diff = r_sh[N-1:0] - dvs_mag;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_nd) state_nxt = DIVIDE;
      DIVIDE:  if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd_sh   <= '0;
      dvs_mag  <= '0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      tag      <= '0;
      out_data <= '0;
      out_m    <= '0;
      out_nd   <= 1'b0;
      error    <= 1'b0;
`ifdef DIVIDE_SIGNED_EN
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      out_nd <= (state == FIX);
      case (state)
        IDLE: begin
          if (in_nd) begin
            tag      <= in_m;
            dvd_sh   <= a_mag;
            dvs_mag  <= b_mag;
            div_zero <= (b_in == '0);
            quo      <= '0;
            rem      <= '0;
            cnt      <= CW'(N - 1);
`ifdef DIVIDE_SIGNED_EN
            q_neg    <= a_in[N-1] ^ b_in[N-1];
            r_neg    <= a_in[N-1];
            ovf      <= ovf_in;
`endif
          end
        end
        DIVIDE: begin
          dvd_sh <= {dvd_sh[N-2:0], 1'b0};
          rem    <= r_ge ? r_diff : r_sh[N-1:0];
          quo    <= {quo[N-2:0], r_ge};
          cnt    <= cnt - CW'(1);
        end
        FIX: begin
          out_data <= {q_fix, r_fix};
          out_m    <= tag;
        end
        default: ;
      endcase

      // A strobe while busy is dropped; faults are flagged when the result is produced
      if (busy && in_nd)
        error <= 1'b1;
`ifdef DIVIDE_SIGNED_EN
      if ((state == FIX) && (div_zero || ovf))
        error <= 1'b1;
`else
      if ((state == FIX) && div_zero)
        error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_divide.sv
// Directed bench for divide (WIDTH=32, N=16); expected values follow DIVIDE_SIGNED_EN.
module tb_divide;

`ifdef DIVIDE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_nd = 1'b0;
  logic [0:0]  in_m = '0;
  logic [31:0] out_data;
  logic        out_nd;
  logic [0:0]  out_m;
  logic        busy;
  logic        error;

  int tests = 0;
  int fails = 0;

  divide #(.WIDTH(32), .MWIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .out_data(out_data), .out_nd(out_nd), .out_m(out_m), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_nd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge right after the accepting edge
  task automatic send(input logic [31:0] d, input logic m);
    in_data = d;
    in_m    = m;
    in_nd   = 1'b1;
    @(negedge clk);
    in_nd   = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt, output logic busy_done);
    lat = 0;
    busy_cnt = 0;
    while (!out_nd && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    busy_done = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    tests++; if (out_nd !== 1'b0) begin fails++; $display("FAIL reset_out_nd got %b want 0", out_nd); end
    tests++; if (out_m !== 1'b0) begin fails++; $display("FAIL reset_out_m got %b want 0", out_m); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
    apply_reset();
  endtask

  task automatic test_basic();
    int lat, bc;
    logic bd;
    send(32'h0064_0007, 1'b1);
    wait_done(lat, bc, bd);
    tests++; if (out_data !== 32'h000E_0002) begin fails++; $display("FAIL basic_data got %h want 000e0002", out_data); end
    tests++; if (out_m !== 1'b1) begin fails++; $display("FAIL basic_tag got %b want 1", out_m); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL basic_latency got %0d want 17", lat); end
    tests++; if (bc !== 17) begin fails++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
    tests++; if (bd !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b want 0", bd); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error got %b want 0", error); end
    @(negedge clk);
    tests++; if (out_nd !== 1'b0 || out_data !== 32'h000E_0002) begin fails++; $display("FAIL basic_hold got nd=%b data=%h want nd=0 data=000e0002", out_nd, out_data); end
  endtask

  task automatic test_negative();
    int lat, bc;
    logic bd;
    logic [31:0] exp;
    send(32'hFF9C_0007, 1'b0);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'hFFF2_FFFE : 32'h2484_0000;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL neg_dividend got %h want %h", out_data, exp); end
    tests++; if (out_m !== 1'b0) begin fails++; $display("FAIL neg_dividend_tag got %b want 0", out_m); end
    send(32'h0064_FFF9, 1'b1);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'hFFF2_0002 : 32'h0000_0064;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL neg_divisor got %h want %h", out_data, exp); end
    send(32'hFFFF_0002, 1'b0);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'h0000_FFFF : 32'h7FFF_0001;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL minus1_by_2 got %h want %h", out_data, exp); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL neg_error got %b want 0", error); end
  endtask

  task automatic test_faults();
    int lat, bc;
    logic bd;
    logic [31:0] exp;
    apply_reset();
    send(32'h0005_0000, 1'b1);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'h7FFF_0005 : 32'hFFFF_0005;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL divzero_pos got %h want %h", out_data, exp); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL divzero_latency got %0d want 17", lat); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL divzero_error got %b want 1", error); end
    apply_reset();
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL error_cleared got %b want 0", error); end
    send(32'h8000_FFFF, 1'b0);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'h7FFF_0000 : 32'h0000_8000;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL overflow got %h want %h", out_data, exp); end
    tests++; if (error !== SGN) begin fails++; $display("FAIL overflow_error got %b want %b", error, SGN); end
    apply_reset();
    send(32'h8000_0000, 1'b1);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'h8000_8000 : 32'hFFFF_8000;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL divzero_minneg got %h want %h", out_data, exp); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL divzero_minneg_error got %b want 1", error); end
    apply_reset();
    send(32'h1234_0000, 1'b0);
    wait_done(lat, bc, bd);
    exp = SGN ? 32'h7FFF_1234 : 32'hFFFF_1234;
    tests++; if (out_data !== exp) begin fails++; $display("FAIL divzero_1234 got %h want %h", out_data, exp); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL divzero_1234_error got %b want 1", error); end
  endtask

  task automatic test_drop();
    int lat;
    apply_reset();
    send(32'h0064_0007, 1'b1);
    lat = 0;
    while (!out_nd && lat < 100) begin
      if (lat == 5) begin
        in_data = 32'h0001_0001;
        in_m    = 1'b0;
        in_nd   = 1'b1;
      end else begin
        in_nd   = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_nd = 1'b0;
    tests++; if (out_data !== 32'h000E_0002) begin fails++; $display("FAIL drop_data got %h want 000e0002", out_data); end
    tests++; if (out_m !== 1'b1) begin fails++; $display("FAIL drop_tag got %b want 1", out_m); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL drop_latency got %0d want 17", lat); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL drop_error got %b want 1", error); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic bd;
    logic [31:0] first;
    apply_reset();
    send(32'h00C8_000A, 1'b0);
    wait_done(lat, bc, bd);
    first = out_data;
    send(32'h03E8_0021, 1'b1);
    tests++; if (first !== 32'h0014_0000) begin fails++; $display("FAIL b2b_first got %h want 00140000", first); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    wait_done(lat, bc, bd);
    tests++; if (out_data !== 32'h001E_000A) begin fails++; $display("FAIL b2b_second got %h want 001e000a", out_data); end
    tests++; if (out_m !== 1'b1) begin fails++; $display("FAIL b2b_tag got %b want 1", out_m); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL b2b_latency got %0d want 17", lat); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL b2b_error got %b want 0", error); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    logic bd;
    apply_reset();
    send(32'h0064_0007, 1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({out_data, out_nd, out_m, busy, error} !== 36'h0) begin fails++; $display("FAIL midreset_outputs got data=%h nd=%b m=%b busy=%b err=%b want all 0", out_data, out_nd, out_m, busy, error); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_nd) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_out_nd got %0d pulses want 0", seen); end
    send(32'h0064_0007, 1'b0);
    wait_done(lat, bc, bd);
    tests++; if (out_data !== 32'h000E_0002) begin fails++; $display("FAIL midreset_after got %h want 000e0002", out_data); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL midreset_latency got %0d want 17", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_faults();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
